rgb_pwm_sequencer: RTL and testbench

//  Programmable 3-channel PWM controller driving the RGB0PWM/RGB1PWM/RGB2PWM inputs of the SB_RGBA_DRV LED driver.

---
 rtl/rgb_pwm_pkg.sv | 41 ++++
 rtl/rgb_pwm_sequencer_timebase.sv | 51 +++++
 rtl/rgb_pwm_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared constants for the RGB PWM sequencer: register map, CTRL/STATUS field
// offsets, mode and FSM state encodings.
package rgb_pwm_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_DUTY     = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_MODE      = 1;
  localparam int CTRL_IRQ_EN    = 3;
  localparam int CTRL_BLINK_LEN = 8;
  localparam int CTRL_STEP      = 16;
  localparam int STAT_ENV       = 8;
  localparam int STAT_CNT       = 16;

  typedef enum logic [1:0] {
    MODE_STATIC     = 2'd0,
    MODE_BLINK      = 2'd1,
    MODE_BREATHE    = 2'd2,
    MODE_STATIC_ALT = 2'd3
  } mode_e;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_STATIC    = 3'd1;
  localparam logic [2:0] ST_BLINK_ON  = 3'd2;
  localparam logic [2:0] ST_BLINK_OFF = 3'd3;
  localparam logic [2:0] ST_BRTH_UP   = 3'd4;
  localparam logic [2:0] ST_BRTH_DN   = 3'd5;

  // Mode 3 aliases static, so comparing start states also compares modes.
  function automatic logic [2:0] start_state(input logic [1:0] mode);
    case (mode_e'(mode))
      MODE_BLINK:   return ST_BLINK_ON;
      MODE_BREATHE: return ST_BRTH_UP;
      default:      return ST_STATIC;
    endcase
  endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_timebase.sv
// Prescaler plus PWM step counter; pb marks the tick on which pwm_cnt wraps.
module pwm_timebase #(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     run_i,
  input  logic                     clr_i,
  input  logic [PRESCALE_BITS-1:0] prescale_i,
  output logic                     tick_o,
  output logic                     pb_o,
  output logic [PWM_BITS-1:0]      pwm_cnt_o
);

  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);
  localparam logic [PWM_BITS-1:0]      PWM_ONE = PWM_BITS'(1);

  logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;

  // >= keeps the prescaler from running to full scale if PRESCALE shrinks mid-count.
  assign tick_o    = run_i && (pre_cnt_q >= prescale_i);
  assign pb_o      = tick_o && (pwm_cnt_q == {PWM_BITS{1'b1}});
  assign pwm_cnt_o = pwm_cnt_q;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    if (clr_i) begin
      pre_cnt_d = '0;
      pwm_cnt_d = '0;
    end else if (tick_o) begin
      pre_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    end else if (run_i) begin
      pre_cnt_d = pre_cnt_q + PRE_ONE;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Three-channel PWM controller for SB_RGBA_DRV: register file, pattern FSM,
// breathe envelope and registered glitch-free compare outputs.
//
// state        | meaning
// OFF       0  | disabled, counters frozen, outputs low
// STATIC    1  | fixed duty
// BLINK_ON  2  | PWM active for BLINK_LEN periods
// BLINK_OFF 3  | outputs low for BLINK_LEN periods
// BRTH_UP   4  | envelope rising by STEP per period
// BRTH_DN   5  | envelope falling by STEP per period
module rgb_pwm_sequencer
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16,
  parameter int BLINK_BITS    = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        red_pwm,
  output logic        green_pwm,
  output logic        blue_pwm,
  output logic        period_irq
);

  localparam logic [BLINK_BITS-1:0] BLINK_ONE = BLINK_BITS'(1);
  localparam logic [2*PWM_BITS-1:0] ENV_ONE   = (2*PWM_BITS)'(1);

  logic                          en_q, en_d, irq_en_q, irq_en_d;
  logic [1:0]                    mode_q, mode_d, mode_sh_q;
  logic [BLINK_BITS-1:0]         blen_q, blen_d, blen_sh_q;
  logic [PWM_BITS-1:0]           step_q, step_d, step_sh_q;
  logic [2:0][PWM_BITS-1:0]      duty_q, duty_d, duty_sh_q;
  logic [PRESCALE_BITS-1:0]      prescale_q, prescale_d;
  logic [2:0]                    state_q, state_d;
  logic [PWM_BITS-1:0]           env_q, env_d, env_up, env_dn;
  logic [PWM_BITS:0]             env_sum;
  logic [BLINK_BITS-1:0]         bcnt_q, bcnt_d, blen_last;
  logic [2:0]                    out_q, out_d;
  logic [2:0][PWM_BITS-1:0]      eff;
  logic [PWM_BITS-1:0]           pwm_cnt;
  logic                          start, run, pb, load_sh, breathe, lit;
  logic                          unused_tick, unused_wdata;

  assign unused_wdata = ^wdata[31:3*PWM_BITS];

  always_comb begin
    en_d       = en_q;
    mode_d     = mode_q;
    irq_en_d   = irq_en_q;
    blen_d     = blen_q;
    step_d     = step_q;
    duty_d     = duty_q;
    prescale_d = prescale_q;
    if (wr_en) begin
      case (addr)
        ADDR_CTRL: begin
          en_d     = wdata[CTRL_EN];
          mode_d   = wdata[CTRL_MODE +: 2];
          irq_en_d = wdata[CTRL_IRQ_EN];
          blen_d   = wdata[CTRL_BLINK_LEN +: BLINK_BITS];
          step_d   = wdata[CTRL_STEP +: PWM_BITS];
        end
        ADDR_DUTY:     duty_d     = wdata[3*PWM_BITS-1:0];
        ADDR_PRESCALE: prescale_d = wdata[PRESCALE_BITS-1:0];
        default: ;
      endcase
    end
  end

  assign start   = en_d && !en_q;
  assign run     = (state_q != ST_OFF);
  // While off the shadows track the registers so the first period after enable is correct.
  assign load_sh = !run || pb;

  pwm_timebase #(
    .PWM_BITS      (PWM_BITS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_timebase (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .run_i      (run),
    .clr_i      (start),
    .prescale_i (prescale_q),
    .tick_o     (unused_tick),
    .pb_o       (pb),
    .pwm_cnt_o  (pwm_cnt)
  );

  assign env_sum   = {1'b0, env_q} + {1'b0, step_sh_q};
  assign env_up    = env_sum[PWM_BITS] ? {PWM_BITS{1'b1}} : env_sum[PWM_BITS-1:0];
  assign env_dn    = (env_q < step_sh_q) ? '0 : env_q - step_sh_q;
  assign blen_last = (blen_sh_q == '0) ? '0 : blen_sh_q - BLINK_ONE;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    bcnt_d  = bcnt_q;
    if (start) begin
      state_d = start_state(mode_d);
      env_d   = '0;
      bcnt_d  = '0;
    end else if (!en_d) begin
      state_d = ST_OFF;
    end else if (pb) begin
      if (start_state(mode_d) != start_state(mode_sh_q)) begin
        state_d = start_state(mode_d);
        env_d   = '0;
        bcnt_d  = '0;
      end else begin
        case (state_q)
          ST_BLINK_ON, ST_BLINK_OFF: begin
            if (bcnt_q == blen_last) begin
              state_d = (state_q == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + BLINK_ONE;
            end
          end
          ST_BRTH_UP: begin
            env_d = env_up;
            if (env_up == {PWM_BITS{1'b1}}) state_d = ST_BRTH_DN;
          end
          ST_BRTH_DN: begin
            env_d = env_dn;
            if (env_dn == '0) state_d = ST_BRTH_UP;
          end
          default: ;
        endcase
      end
    end
  end

  assign breathe = (state_q == ST_BRTH_UP) || (state_q == ST_BRTH_DN);
  assign lit     = en_d && run && (state_q != ST_BLINK_OFF);

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [2*PWM_BITS-1:0] prod;
    assign prod     = {{PWM_BITS{1'b0}}, duty_sh_q[c]} * ({{PWM_BITS{1'b0}}, env_q} + ENV_ONE);
    assign eff[c]   = !breathe ? duty_sh_q[c] :
                      (env_q == '0) ? '0 : PWM_BITS'(prod >> PWM_BITS);
    assign out_d[c] = lit && (pwm_cnt < eff[c]);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      en_q       <= 1'b0;
      mode_q     <= '0;
      irq_en_q   <= 1'b0;
      blen_q     <= '0;
      step_q     <= '0;
      duty_q     <= '0;
      prescale_q <= '0;
      mode_sh_q  <= '0;
      blen_sh_q  <= '0;
      step_sh_q  <= '0;
      duty_sh_q  <= '0;
      state_q    <= ST_OFF;
      env_q      <= '0;
      bcnt_q     <= '0;
      out_q      <= '0;
    end else begin
      en_q       <= en_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      blen_q     <= blen_d;
      step_q     <= step_d;
      duty_q     <= duty_d;
      prescale_q <= prescale_d;
      if (load_sh) begin
        mode_sh_q <= mode_d;
        blen_sh_q <= blen_d;
        step_sh_q <= step_d;
        duty_sh_q <= duty_d;
      end
      state_q    <= state_d;
      env_q      <= env_d;
      bcnt_q     <= bcnt_d;
      out_q      <= out_d;
    end
  end

  assign red_pwm    = out_q[0];
  assign green_pwm  = out_q[1];
  assign blue_pwm   = out_q[2];
  assign period_irq = pb && irq_en_q && run;

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL: begin
        rdata[CTRL_EN]                        = en_q;
        rdata[CTRL_MODE +: 2]                 = mode_q;
        rdata[CTRL_IRQ_EN]                    = irq_en_q;
        rdata[CTRL_BLINK_LEN +: BLINK_BITS]   = blen_q;
        rdata[CTRL_STEP +: PWM_BITS]          = step_q;
      end
      ADDR_DUTY:     rdata[3*PWM_BITS-1:0]    = duty_q;
      ADDR_PRESCALE: rdata[PRESCALE_BITS-1:0] = prescale_q;
      ADDR_STATUS: begin
        rdata[2:0]                   = state_q;
        rdata[STAT_ENV +: PWM_BITS]  = env_q;
        rdata[STAT_CNT +: PWM_BITS]  = pwm_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer: reset, registers, static, glitch-free
// update, blink, breathe, interrupt and disable behaviour.
module tb_rgb_pwm_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        red_pwm, green_pwm, blue_pwm, period_irq;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  rgb_pwm_sequencer dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .wr_en      (wr_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .red_pwm    (red_pwm),
    .green_pwm  (green_pwm),
    .blue_pwm   (blue_pwm),
    .period_irq (period_irq)
  );

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge HCLK); #1;
    wr_en = 1'b0;
    wdata = '0;
    addr  = 2'd3;
  endtask

  // Samples n cycles, counting high outputs; optional write issued at cycle wr_at.
  task automatic run_cycles(input int n, input int wr_at, input logic [1:0] wa,
                            input logic [31:0] wd, output int r, output int g,
                            output int b, output logic [31:0] st_mid);
    r = 0; g = 0; b = 0; st_mid = '0;
    addr = 2'd3;
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        addr = wa; wdata = wd; wr_en = 1'b1;
      end
      @(posedge HCLK); #1;
      if (i == wr_at) begin
        wr_en = 1'b0; wdata = '0; addr = 2'd3;
      end
      if (red_pwm)   r++;
      if (green_pwm) g++;
      if (blue_pwm)  b++;
      if (i == n / 2) st_mid = rdata;
    end
  endtask

  task automatic test_reset;
    HRESET = 1'b1; wr_en = 1'b0; addr = 2'd0; wdata = '0;
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if ({red_pwm, green_pwm, blue_pwm, period_irq} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {red_pwm, green_pwm, blue_pwm, period_irq});
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      checks++;
      if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata addr%0d: got %h expected 00000000", a, rdata);
      end
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_regs;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h00FF_FF0E;
    exp_rd[1] = 32'h00FF_FFFF;
    exp_rd[2] = 32'h0000_FFFF;
    exp_rd[3] = 32'h0000_0000;
    write_reg(2'd0, 32'hFFFF_FFFE);
    write_reg(2'd1, 32'hFFFF_FFFF);
    write_reg(2'd2, 32'hFFFF_FFFF);
    write_reg(2'd3, 32'hFFFF_FFFF);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      checks++;
      if (rdata !== exp_rd[a]) begin
        errors++;
        $display("FAIL reg_readback addr%0d: got %h expected %h", a, rdata, exp_rd[a]);
      end
    end
    write_reg(2'd0, 32'h0);
    write_reg(2'd1, 32'h0);
    write_reg(2'd2, 32'h0);
  endtask

  task automatic test_static;
    int r, g, b;
    logic [31:0] st;
    write_reg(2'd2, 32'h0);
    write_reg(2'd1, 32'h00FF_0040);
    write_reg(2'd0, 32'h0000_0007);
    for (int p = 0; p < 2; p++) begin
      run_cycles(256, -1, 2'd0, 32'h0, r, g, b, st);
      checks++;
      if (r !== 64 || g !== 0 || b !== 255) begin
        errors++;
        $display("FAIL static_counts p%0d: got r=%0d g=%0d b=%0d expected r=64 g=0 b=255", p, r, g, b);
      end
      checks++;
      if (st[2:0] !== 3'd1) begin
        errors++;
        $display("FAIL static_state p%0d: got %0d expected 1", p, st[2:0]);
      end
    end
  endtask

  task automatic test_glitch_free;
    int r, g, b;
    logic [31:0] st;
    run_cycles(256, 100, 2'd1, 32'h00FF_00C8, r, g, b, st);
    checks++;
    if (r !== 64 || b !== 255) begin
      errors++;
      $display("FAIL glitch_cur_period: got r=%0d b=%0d expected r=64 b=255", r, b);
    end
    run_cycles(256, -1, 2'd0, 32'h0, r, g, b, st);
    checks++;
    if (r !== 200 || b !== 255) begin
      errors++;
      $display("FAIL glitch_next_period: got r=%0d b=%0d expected r=200 b=255", r, b);
    end
  endtask

  task automatic test_blink;
    int r, g, b;
    logic [31:0] st;
    int exp_r  [6] = '{128, 128, 0, 0, 128, 128};
    int exp_st [6] = '{2, 2, 3, 3, 2, 2};
    write_reg(2'd0, 32'h0);
    write_reg(2'd1, 32'h0000_0080);
    write_reg(2'd0, 32'h0000_0203);
    for (int p = 0; p < 6; p++) begin
      run_cycles(256, -1, 2'd0, 32'h0, r, g, b, st);
      checks++;
      if (r !== exp_r[p] || g !== 0 || b !== 0) begin
        errors++;
        $display("FAIL blink_counts p%0d: got r=%0d g=%0d b=%0d expected r=%0d g=0 b=0", p, r, g, b, exp_r[p]);
      end
      checks++;
      if (int'(st[2:0]) !== exp_st[p]) begin
        errors++;
        $display("FAIL blink_state p%0d: got %0d expected %0d", p, st[2:0], exp_st[p]);
      end
    end
  endtask

  task automatic test_breathe;
    int r, g, b;
    logic [31:0] st;
    int exp_env [9] = '{0, 64, 128, 192, 255, 191, 127, 63, 0};
    int exp_r   [9] = '{0, 64, 128, 192, 255, 191, 127, 63, 0};
    int exp_g   [9] = '{0, 32, 64, 96, 128, 96, 64, 32, 0};
    int exp_st  [9] = '{4, 4, 4, 4, 5, 5, 5, 5, 4};
    write_reg(2'd0, 32'h0);
    write_reg(2'd1, 32'h0000_80FF);
    write_reg(2'd0, 32'h0040_0005);
    for (int p = 0; p < 9; p++) begin
      run_cycles(256, -1, 2'd0, 32'h0, r, g, b, st);
      checks++;
      if (r !== exp_r[p] || g !== exp_g[p] || b !== 0) begin
        errors++;
        $display("FAIL breathe_counts p%0d: got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=0", p, r, g, b, exp_r[p], exp_g[p]);
      end
      checks++;
      if (int'(st[15:8]) !== exp_env[p] || int'(st[2:0]) !== exp_st[p]) begin
        errors++;
        $display("FAIL breathe_status p%0d: got env=%0d state=%0d expected env=%0d state=%0d", p, st[15:8], st[2:0], exp_env[p], exp_st[p]);
      end
    end
  endtask

  task automatic test_irq_disable;
    int pulses = 0, misplaced = 0, r = 0, lit = 0;
    write_reg(2'd0, 32'h0);
    write_reg(2'd1, 32'h0000_0040);
    write_reg(2'd2, 32'h0000_0001);
    write_reg(2'd0, 32'h0000_0009);
    for (int k = 1; k <= 1536; k++) begin
      @(posedge HCLK); #1;
      if (period_irq) begin
        pulses++;
        if (k % 512 != 511) misplaced++;
      end
      if (k <= 512 && red_pwm) r++;
    end
    checks++;
    if (pulses !== 3 || misplaced !== 0) begin
      errors++;
      $display("FAIL irq_pulses: got %0d pulses (%0d misplaced) expected 3 at cycles 511/1023/1535", pulses, misplaced);
    end
    checks++;
    if (r !== 128) begin
      errors++;
      $display("FAIL prescale_red: got %0d expected 128", r);
    end
    write_reg(2'd0, 32'h0000_0008);
    pulses = 0;
    for (int k = 0; k < 1100; k++) begin
      if (period_irq) pulses++;
      if (red_pwm || green_pwm || blue_pwm) lit++;
      @(posedge HCLK); #1;
    end
    checks++;
    if (pulses !== 0 || lit !== 0) begin
      errors++;
      $display("FAIL disable_quiet: got %0d irq and %0d lit cycles expected 0 and 0", pulses, lit);
    end
    addr = 2'd3; #1;
    checks++;
    if (rdata[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL disable_state: got %0d expected 0", rdata[2:0]);
    end
  endtask

  task automatic test_reset_mid;
    write_reg(2'd0, 32'h0);
    write_reg(2'd2, 32'h0);
    write_reg(2'd1, 32'h00FF_FFFF);
    write_reg(2'd0, 32'h0000_0009);
    repeat (100) @(posedge HCLK);
    #1;
    checks++;
    if ({red_pwm, green_pwm, blue_pwm} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_lit: got %b expected 111", {red_pwm, green_pwm, blue_pwm});
    end
    HRESET = 1'b1;
    #2;
    checks++;
    if ({red_pwm, green_pwm, blue_pwm, period_irq} !== 4'b0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %b expected 0000", {red_pwm, green_pwm, blue_pwm, period_irq});
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      checks++;
      if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL midrun_reset_rdata addr%0d: got %h expected 00000000", a, rdata);
      end
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
  endtask

  initial begin
    test_reset;
    test_regs;
    test_static;
    test_glitch_free;
    test_blink;
    test_breathe;
    test_irq_disable;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
